// File: rtl/pulse_det_pkg.sv
// Shared types for the bounded-width pulse detector: per-channel FSM state encoding.
// No timing of its own; no backpressure.
package pulse_det_pkg;

    typedef enum logic [1:0] {
        PD_LOW  = 2'd0,
        PD_HIGH = 2'd1,
        PD_LONG = 2'd2
    } pd_state_t;

endpackage

// File: rtl/pulse_width_detector_ch.sv
// One channel: classifies high runs of a as accepted (MIN_W..MAX_W) or overlong, counts accepted pulses.
// Flags are combinational from registered state and current a; no backpressure, every cycle is consumed.
module pulse_width_detector_ch
    import pulse_det_pkg::*;
#(
    parameter int MIN_W    = 1,
    parameter int MAX_W    = 1,
    parameter int OK_CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a,
    input  logic                clr,
    output logic                rise,
    output logic                fall,
    output logic                pulse_ok,
    output logic                too_long,
    output logic [OK_CNT_W-1:0] ok_cnt
);

    localparam int W_CNT = (MAX_W < 1) ? 1 : $clog2(MAX_W + 1);
    localparam logic [W_CNT-1:0]    MIN_C  = W_CNT'(MIN_W);
    localparam logic [W_CNT-1:0]    MAX_C  = W_CNT'(MAX_W);
    localparam logic [OK_CNT_W-1:0] OK_SAT = '1;

    if (MIN_W < 1 || MAX_W < MIN_W) begin : g_bad_width
        $error("pulse_width_detector_ch: need 1 <= MIN_W <= MAX_W");
    end

    pd_state_t             state_q, state_d;
    logic [W_CNT-1:0]      cnt_q, cnt_d;
    logic [OK_CNT_W-1:0]   ok_cnt_q, ok_cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rise     = 1'b0;
        fall     = 1'b0;
        pulse_ok = 1'b0;
        too_long = 1'b0;
        case (state_q)
            PD_LOW: begin
                if (a) begin
                    state_d = PD_HIGH;
                    cnt_d   = W_CNT'(1);
                    rise    = 1'b1;
                end
            end
            PD_HIGH: begin
                if (a) begin
                    // cnt saturates at MAX_W; the LONG state remembers the overflow
                    if (cnt_q == MAX_C) begin
                        state_d  = PD_LONG;
                        too_long = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d  = PD_LOW;
                    cnt_d    = '0;
                    fall     = 1'b1;
                    pulse_ok = (cnt_q >= MIN_C);
                end
            end
            PD_LONG: begin
                if (!a) begin
                    state_d = PD_LOW;
                    cnt_d   = '0;
                    fall    = 1'b1;
                end
            end
            default: begin
                state_d = PD_LOW;
                cnt_d   = '0;
            end
        endcase
        if (rst) begin
            rise     = 1'b0;
            fall     = 1'b0;
            pulse_ok = 1'b0;
            too_long = 1'b0;
        end
    end

    // A clear coinciding with an accepted pulse keeps that pulse.
    always_comb begin
        ok_cnt_d = ok_cnt_q;
        if (clr) begin
            ok_cnt_d = pulse_ok ? OK_CNT_W'(1) : '0;
        end else if (pulse_ok && ok_cnt_q != OK_SAT) begin
            ok_cnt_d = ok_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PD_LOW;
            cnt_q    <= '0;
            ok_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ok_cnt_q <= ok_cnt_d;
        end
    end

    assign ok_cnt = ok_cnt_q;

endmodule

// File: rtl/multi_channel_pulse_width_detector.sv
// N_CH independent bounded-width pulse detectors with packed per-channel accepted-pulse counters.
// Flags combinational from state and current a (0-cycle); no backpressure.
module multi_channel_pulse_width_detector
    import pulse_det_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int MIN_W    = 1,
    parameter int MAX_W    = 1,
    parameter int OK_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            a,
    input  logic                       clr,
    output logic [N_CH-1:0]            rise,
    output logic [N_CH-1:0]            fall,
    output logic [N_CH-1:0]            pulse_ok,
    output logic [N_CH-1:0]            too_long,
    output logic [N_CH*OK_CNT_W-1:0]   ok_cnt
);

    if (N_CH < 1) begin : g_bad_nch
        $error("multi_channel_pulse_width_detector: N_CH must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_width_detector_ch #(
            .MIN_W    (MIN_W),
            .MAX_W    (MAX_W),
            .OK_CNT_W (OK_CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .a        (a[i]),
            .clr      (clr),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .pulse_ok (pulse_ok[i]),
            .too_long (too_long[i]),
            .ok_cnt   (ok_cnt[i*OK_CNT_W +: OK_CNT_W])
        );
    end

endmodule
